query_sequencer: RTL and testbench

Host-facing controller that sequences one nearest-neighbour search on the `bfis` engine. It frames query words arriving from the host debug register (`manta` output) behind a sync word and assembles the DIM-element query plus `k`. It then launches the engine with a one-cycle start pulse and forwards exactly `k` results into the output FIFO. It replaces the ad-hoc loader logic in `top_level` and adds a result handshake, error flagging and a single explicit state machine.

---
 rtl/query_seq_pkg.sv | 22 ++
 rtl/word_event_detect.sv | 29 ++
 rtl/query_sequencer.sv | 138 +++++++++++++
 tb/tb_query_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/query_seq_pkg.sv
// Shared types and constants for the nearest-neighbour query sequencer.
package query_seq_pkg;

    localparam int WORD_W = 32;
    localparam int K_W    = 16;
    localparam logic [WORD_W-1:0] SYNC_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } qs_state_t;

    // A result count is usable when it is non-zero and no larger than the limit.
    function automatic logic k_in_range(input logic [K_W-1:0] k,
                                        input logic [K_W-1:0] k_max);
        return (k != {K_W{1'b0}}) && (k <= k_max);
    endfunction

endpackage

// File: rtl/word_event_detect.sv
// Turns a level-style host register into events: an event fires whenever the
// register value differs from the value seen on the previous cycle.
module word_event_detect
    import query_seq_pkg::*;
#(
    parameter logic [WORD_W-1:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [WORD_W-1:0] word_in,
    output logic              event_out,
    output logic              is_sync_out
);

    logic [WORD_W-1:0] r_last_word;

    // Track the previous cycle's host value in every cycle, regardless of state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_last_word <= {WORD_W{1'b0}};
        end else begin
            r_last_word <= word_in;
        end
    end

    assign event_out   = (word_in != r_last_word);
    assign is_sync_out = event_out && (word_in == SYNC_WORD);

endmodule

// File: rtl/query_sequencer.sv
// Frames host words into a query plus result count, launches the search engine
// with a one-cycle pulse, and forwards exactly k results into the output FIFO.
module query_sequencer
    import query_seq_pkg::*;
#(
    parameter int                DIM       = 8,
    parameter int                K_MAX     = 16,
    parameter logic [WORD_W-1:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [WORD_W-1:0]          host_word_in,
    output logic [DIM-1:0][WORD_W-1:0] query_out,
    output logic [K_W-1:0]             k_out,
    output logic                       start_out,
    input  logic [WORD_W-1:0]          result_in,
    input  logic                       result_valid_in,
    output logic [WORD_W-1:0]          fifo_data_out,
    output logic                       fifo_enq_out,
    input  logic                       fifo_full_in,
    output logic                       busy_out,
    output logic                       error_out,
    output logic [2:0]                 state_out,
    output logic [4:0]                 words_loaded_out
);

    // Counts 0..DIM+1 so the k word's capture is visible as DIM+1.
    localparam int LD_W = $clog2(DIM + 2);

    logic                       w_event;
    logic                       w_is_sync;

    qs_state_t                  r_state;
    logic [LD_W-1:0]            r_ld_cnt;
    logic [DIM-1:0][WORD_W-1:0] r_buf;
    logic [DIM-1:0][WORD_W-1:0] r_query;
    logic [K_W-1:0]             r_k;
    logic [K_W-1:0]             r_res_cnt;
    logic                       r_start;
    logic                       r_error;

    word_event_detect #(
        .SYNC_WORD (SYNC_WORD)
    ) u_event (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .word_in     (host_word_in),
        .event_out   (w_event),
        .is_sync_out (w_is_sync)
    );

    // Sequencer FSM: framing, launch pulse, result counting and error flagging.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= ST_IDLE;
            r_ld_cnt  <= {LD_W{1'b0}};
            r_buf     <= '0;
            r_query   <= '0;
            r_k       <= {K_W{1'b0}};
            r_res_cnt <= {K_W{1'b0}};
            r_start   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_is_sync) begin
                        r_state  <= ST_LOAD;
                        r_ld_cnt <= {LD_W{1'b0}};
                        r_error  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_is_sync) begin
                        // A fresh sync abandons the partial frame.
                        r_ld_cnt <= {LD_W{1'b0}};
                        r_error  <= 1'b0;
                    end else if (w_event) begin
                        r_ld_cnt <= r_ld_cnt + LD_W'(1);
                        if (r_ld_cnt == LD_W'(DIM)) begin
                            if (k_in_range(host_word_in[K_W-1:0], K_W'(K_MAX))) begin
                                r_query <= r_buf;
                                r_k     <= host_word_in[K_W-1:0];
                                r_start <= 1'b1;
                                r_state <= ST_LAUNCH;
                            end else begin
                                // Bad k: keep the previous query/k visible to the engine.
                                r_error <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            for (int i = 0; i < DIM; i++) begin
                                if (r_ld_cnt == LD_W'(i)) begin
                                    r_buf[i] <= host_word_in;
                                end
                            end
                        end
                    end
                end
                ST_LAUNCH: begin
                    r_res_cnt <= {K_W{1'b0}};
                    r_state   <= ST_RUN;
                end
                ST_RUN: begin
                    // Host traffic is ignored here; only engine results matter.
                    if (result_valid_in) begin
                        r_res_cnt <= r_res_cnt + K_W'(1);
                        if (fifo_full_in) begin
                            r_error <= 1'b1;
                        end
                        if ((r_res_cnt + K_W'(1)) == r_k) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign query_out        = r_query;
    assign k_out            = r_k;
    assign start_out        = r_start;
    assign error_out        = r_error;
    assign state_out        = r_state;
    assign busy_out         = (r_state != ST_IDLE);
    assign words_loaded_out = 5'(r_ld_cnt);

    // Results pass straight through to the FIFO with no added latency.
    assign fifo_enq_out  = (r_state == ST_RUN) && result_valid_in && !fifo_full_in;
    assign fifo_data_out = (r_state == ST_RUN) ? result_in : {WORD_W{1'b0}};

endmodule

// File: tb/tb_query_sequencer.sv
// Self-checking bench for query_sequencer: table-driven frames plus hand
// sequences for resync, reset during RUN and host traffic during RUN.
module tb_query_sequencer;

    localparam int          DIM   = 8;
    localparam int          K_MAX = 16;
    localparam logic [31:0] SYNC  = 32'hFFFF_FFFF;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [31:0]            host_word;
    logic [DIM-1:0][31:0]   query_out;
    logic [15:0]            k_out;
    logic                   start_out;
    logic [31:0]            result;
    logic                   result_valid;
    logic [31:0]            fifo_data_out;
    logic                   fifo_enq_out;
    logic                   fifo_full;
    logic                   busy_out;
    logic                   error_out;
    logic [2:0]             state_out;
    logic [4:0]             words_loaded_out;

    always #5 clk = ~clk;

    query_sequencer #(.DIM(DIM), .K_MAX(K_MAX), .SYNC_WORD(SYNC)) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .host_word_in     (host_word),
        .query_out        (query_out),
        .k_out            (k_out),
        .start_out        (start_out),
        .result_in        (result),
        .result_valid_in  (result_valid),
        .fifo_data_out    (fifo_data_out),
        .fifo_enq_out     (fifo_enq_out),
        .fifo_full_in     (fifo_full),
        .busy_out         (busy_out),
        .error_out        (error_out),
        .state_out        (state_out),
        .words_loaded_out (words_loaded_out)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic [DIM-1:0][31:0] words;
        logic [31:0]          k_word;
        int                   n_res;
        logic [31:0]          full_mask;
        bit                   exp_start;
        bit                   exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every FIFO enqueue must match the oldest result expected to pass.
    always @(negedge clk) begin
        if (fifo_enq_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL fifo_unexpected: got enqueue of %0h, expected none", fifo_data_out);
            end else begin
                chk("fifo_data", fifo_data_out, sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] w);
        host_word = w;
        tick();
    endtask

    task automatic chk_query(input string nm, input logic [DIM-1:0][31:0] exp);
        for (int i = 0; i < DIM; i++) begin
            chk($sformatf("%s[%0d]", nm, i), query_out[i], exp[i]);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_state"}, state_out, 3'd0);
        chk({nm, "_query"}, query_out, 0);
        chk({nm, "_k"}, k_out, 16'd0);
        chk({nm, "_start"}, start_out, 1'b0);
        chk({nm, "_enq"}, fifo_enq_out, 1'b0);
        chk({nm, "_fdata"}, fifo_data_out, 32'd0);
        chk({nm, "_busy"}, busy_out, 1'b0);
        chk({nm, "_err"}, error_out, 1'b0);
        chk({nm, "_wl"}, words_loaded_out, 5'd0);
    endtask

    // Sync + DIM words + k; checks the LAUNCH cycle (or rejection) and enters RUN.
    task automatic load_frame(input string nm, input logic [DIM-1:0][31:0] words,
                              input logic [31:0] k_word, input bit exp_start);
        logic [DIM-1:0][31:0] q_before;
        logic [15:0]          k_before;
        q_before = query_out;
        k_before = k_out;
        send(SYNC);
        chk({nm, "_sync_state"}, state_out, 3'd1);
        chk({nm, "_sync_wl"}, words_loaded_out, 5'd0);
        chk({nm, "_sync_err"}, error_out, 1'b0);
        chk({nm, "_sync_busy"}, busy_out, 1'b1);
        for (int i = 0; i < DIM; i++) begin
            send(words[i]);
            chk($sformatf("%s_wl%0d", nm, i), words_loaded_out, 5'(i + 1));
        end
        send(k_word);
        chk({nm, "_wl_peak"}, words_loaded_out, 5'(DIM + 1));
        if (exp_start) begin
            chk({nm, "_launch_state"}, state_out, 3'd2);
            chk({nm, "_start"}, start_out, 1'b1);
            chk({nm, "_k"}, k_out, k_word[15:0]);
            chk_query({nm, "_query"}, words);
            tick();
            chk({nm, "_run_state"}, state_out, 3'd3);
            chk({nm, "_start_low"}, start_out, 1'b0);
        end else begin
            chk({nm, "_rej_state"}, state_out, 3'd0);
            chk({nm, "_rej_start"}, start_out, 1'b0);
            chk({nm, "_rej_err"}, error_out, 1'b1);
            chk({nm, "_rej_busy"}, busy_out, 1'b0);
            chk({nm, "_rej_k"}, k_out, k_before);
            chk_query({nm, "_rej_query"}, q_before);
        end
    endtask

    // Engine model: n results, FIFO full on results flagged in mask,
    // optional host traffic in parallel that must be ignored.
    task automatic run_results(input string nm, input int n, input logic [31:0] mask,
                               input bit inject, input bit exp_err);
        for (int j = 0; j < n; j++) begin
            result_valid = 1'b1;
            result       = $urandom;
            fifo_full    = mask[j];
            if (!mask[j]) sb_q.push_back(result);
            if (inject) host_word = (j % 2 == 1) ? SYNC : (32'h5A00_0000 + 32'(j));
            tick();
            chk($sformatf("%s_res%0d_state", nm, j), state_out, (j == n - 1) ? 3'd4 : 3'd3);
            if (inject) chk($sformatf("%s_res%0d_wl", nm, j), words_loaded_out, 5'(DIM + 1));
        end
        result_valid = 1'b0;
        fifo_full    = 1'b0;
        tick();
        chk({nm, "_idle_state"}, state_out, 3'd0);
        chk({nm, "_idle_busy"}, busy_out, 1'b0);
        chk({nm, "_err"}, error_out, exp_err);
        chk({nm, "_sb_empty"}, sb_q.size(), 0);
    endtask

    initial begin
        logic [DIM-1:0][31:0] w;

        // Adjacent equal host words merge into one, so every frame avoids them.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < DIM; i++) vecs[v].words[i] = 32'h100 * 32'(v + 1) + 32'(i);
            vecs[v].full_mask = 32'd0;
            vecs[v].exp_start = 1'b1;
            vecs[v].exp_err   = 1'b0;
        end
        w[0] = 32'd5; w[1] = 32'd7; w[2] = 32'd1; w[3] = 32'd2;
        w[4] = 32'd5; w[5] = 32'd7; w[6] = 32'd1; w[7] = 32'd2;
        vecs[0].words = w;    vecs[0].k_word = 32'd4;          vecs[0].n_res = 4;
        vecs[1].k_word = 32'd0;                                vecs[1].n_res = 0;
        vecs[1].exp_start = 1'b0; vecs[1].exp_err = 1'b1;
        vecs[2].k_word = 32'(K_MAX + 1);                       vecs[2].n_res = 0;
        vecs[2].exp_start = 1'b0; vecs[2].exp_err = 1'b1;
        vecs[3].k_word = 32'd3;   vecs[3].n_res = 3;  vecs[3].full_mask = 32'b010;
        vecs[3].exp_err = 1'b1;
        vecs[4].k_word = 32'hABCD_0000 | 32'(K_MAX);           vecs[4].n_res = K_MAX;
        vecs[5].k_word = 32'd1;                                vecs[5].n_res = 1;

        rst = 1'b1; host_word = 32'd0; result = 32'd0; result_valid = 1'b0; fifo_full = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk_reset_outputs("por");
        tick();

        for (int v = 0; v < 6; v++) begin
            load_frame($sformatf("v%0d", v), vecs[v].words, vecs[v].k_word, vecs[v].exp_start);
            if (vecs[v].exp_start)
                run_results($sformatf("v%0d", v), vecs[v].n_res, vecs[v].full_mask, 1'b0, vecs[v].exp_err);
        end

        // Resync mid-frame: the first three words are discarded.
        send(SYNC);
        send(32'hDEAD_0001); send(32'hDEAD_0002); send(32'hDEAD_0003);
        chk("resync_wl3", words_loaded_out, 5'd3);
        for (int i = 0; i < DIM; i++) w[i] = 32'h7700 + 32'(i);
        load_frame("resync", w, 32'd2, 1'b1);
        run_results("resync", 2, 32'd0, 1'b0, 1'b0);

        // Reset during RUN after one of four results.
        for (int i = 0; i < DIM; i++) w[i] = 32'h8800 + 32'(i);
        load_frame("rstrun", w, 32'd4, 1'b1);
        result_valid = 1'b1; result = 32'hCAFE_0001; sb_q.push_back(result);
        tick();
        chk("rstrun_mid_state", state_out, 3'd3);
        result_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("rstrun_after");
        tick();
        chk("rstrun_idle", state_out, 3'd0);
        for (int i = 0; i < DIM; i++) w[i] = 32'h9900 + 32'(i);
        load_frame("postrst", w, 32'd1, 1'b1);
        run_results("postrst", 1, 32'd0, 1'b0, 1'b0);

        // Host sync/data events while in RUN are ignored.
        for (int i = 0; i < DIM; i++) w[i] = 32'hAA00 + 32'(i);
        load_frame("ignore", w, 32'd3, 1'b1);
        run_results("ignore", 3, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < DIM; i++) w[i] = 32'hBB00 + 32'(i);
        load_frame("after_ign", w, 32'd2, 1'b1);
        run_results("after_ign", 2, 32'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
